// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the multi-lane TMDS encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tmds_pkg;

    // Width of the signed per-lane running disparity counter.
    localparam int DISP_W = 5;

    // Per-cycle symbol mode, common to all lanes.
    localparam logic [1:0] MODE_CTRL  = 2'b00;
    localparam logic [1:0] MODE_VIDEO = 2'b01;
    localparam logic [1:0] MODE_DATA  = 2'b10;
    localparam logic [1:0] MODE_GUARD = 2'b11;

    // Control tokens indexed by {c1,c0}; bit 0 goes on the wire first.
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    // Video guard band: even lanes (0, 2) and odd lanes (1, 3) differ.
    localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
    localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

    // Contents of the stage-1 pipeline register of one lane.
    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] ctrl;
        logic [3:0] aux;
        logic [8:0] qm;
    } s1_t;

    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising first step of 8b/10b video coding.
    // XNOR chaining is chosen for bytes with many ones so q_m has fewer
    // transitions; q_m[8] records which chain was used (1 = XOR).
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Control token for {c1,c0}.
    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_TOKEN_00;
            2'b01:   t = CTRL_TOKEN_01;
            2'b10:   t = CTRL_TOKEN_10;
            default: t = CTRL_TOKEN_11;
        endcase
        return t;
    endfunction

    // TERC4 symbol for a data-island nibble.
    function automatic logic [9:0] terc4(input logic [3:0] d);
        logic [9:0] t;
        case (d)
            4'h0:    t = 10'b1010011100;
            4'h1:    t = 10'b1001100011;
            4'h2:    t = 10'b1011100100;
            4'h3:    t = 10'b1011100010;
            4'h4:    t = 10'b0101110001;
            4'h5:    t = 10'b0100011110;
            4'h6:    t = 10'b0110001110;
            4'h7:    t = 10'b0100111100;
            4'h8:    t = 10'b1011001100;
            4'h9:    t = 10'b0100111001;
            4'hA:    t = 10'b0110011100;
            4'hB:    t = 10'b1011000110;
            4'hC:    t = 10'b1010001110;
            4'hD:    t = 10'b1001110001;
            4'hE:    t = 10'b0101100011;
            default: t = 10'b1011000011;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: 8b/10b video with DC balance, control tokens, TERC4, guard bands.
// Latency: 2 cycles from input sample to dout/disp; one symbol per cycle.
// Backpressure: none; the lane never stalls and accepts a symbol every cycle.
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter int LANE      = 0,
    parameter bit USE_TERC4 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [7:0]        din,
    input  logic [1:0]        ctrl,
    input  logic [3:0]        aux,
    output logic [9:0]        dout,
    output logic [DISP_W-1:0] disp
);

    localparam logic [9:0] GUARD_SYM = ((LANE % 2) == 0) ? GUARD_EVEN : GUARD_ODD;

    s1_t               s1_nxt;
    s1_t               s1;
    logic [3:0]        n1q;
    logic [DISP_W-1:0] d10;
    logic [DISP_W-1:0] cnt;
    logic [DISP_W-1:0] cnt_nxt;
    logic              cnt_pos;
    logic              cnt_neg;
    logic [9:0]        sym_nxt;

    // Stage 1 next state: q_m plus the side-band needed by stage 2.
    // Without TERC4 support a DATA request is folded into CTRL here so
    // stage 2 never sees it.
    always_comb begin
        s1_nxt      = '0;
        s1_nxt.qm   = tmds_qm(din);
        s1_nxt.ctrl = ctrl;
        s1_nxt.aux  = aux;
        s1_nxt.mode = mode;
        if (!USE_TERC4 && (mode == MODE_DATA)) begin
            s1_nxt.mode = MODE_CTRL;
        end
    end

    // Stage 1 register; reset loads an idle CTRL/00 symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1.mode <= MODE_CTRL;
            s1.ctrl <= 2'b00;
            s1.aux  <= '0;
            s1.qm   <= '0;
        end else begin
            s1 <= s1_nxt;
        end
    end

    // Sign tests on the two's-complement disparity counter.
    assign cnt_neg = cnt[DISP_W-1];
    assign cnt_pos = !cnt[DISP_W-1] && (cnt != '0);

    // Stage 2 next state: final symbol and updated running disparity.
    // d10 is (ones - zeros) of q_m[7:0]; all arithmetic is modulo 2^DISP_W,
    // which is exact because the balanced counter stays within -8..+8.
    always_comb begin
        n1q     = popcount8(s1.qm[7:0]);
        d10     = DISP_W'(n1q) + DISP_W'(n1q) - DISP_W'(8);
        sym_nxt = CTRL_TOKEN_00;
        cnt_nxt = '0;
        case (s1.mode)
            MODE_VIDEO: begin
                if ((cnt == '0) || (n1q == 4'd4)) begin
                    sym_nxt = {~s1.qm[8], s1.qm[8], s1.qm[8] ? s1.qm[7:0] : ~s1.qm[7:0]};
                    cnt_nxt = s1.qm[8] ? (cnt + d10) : (cnt - d10);
                end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
                    sym_nxt = {1'b1, s1.qm[8], ~s1.qm[7:0]};
                    cnt_nxt = cnt + {{(DISP_W-2){1'b0}}, s1.qm[8], 1'b0} - d10;
                end else begin
                    sym_nxt = {1'b0, s1.qm[8], s1.qm[7:0]};
                    cnt_nxt = cnt + d10 - (s1.qm[8] ? DISP_W'(0) : DISP_W'(2));
                end
            end
            MODE_DATA:  sym_nxt = terc4(s1.aux);
            MODE_GUARD: sym_nxt = GUARD_SYM;
            default:    sym_nxt = ctrl_token(s1.ctrl);
        endcase
    end

    // Stage 2 register: output symbol and disparity (non-video clears it).
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= CTRL_TOKEN_00;
            cnt  <= '0;
        end else begin
            dout <= sym_nxt;
            cnt  <= cnt_nxt;
        end
    end

    assign disp = cnt;

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS/HDMI encoder: NCH independent lanes sharing one mode input.
// Latency: 2 cycles; one 10-bit symbol per lane per pixel clock.
// Backpressure: none; downstream serialisers consume every cycle.
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int NCH       = 3,
    parameter bit USE_TERC4 = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [8*NCH-1:0]      din,
    input  logic [2*NCH-1:0]      ctrl,
    input  logic [4*NCH-1:0]      aux,
    output logic [10*NCH-1:0]     dout,
    output logic [DISP_W*NCH-1:0] disp
);

    // One encoder per lane; the lane index selects the guard-band pattern.
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        tmds_lane_enc #(
            .LANE      (i),
            .USE_TERC4 (USE_TERC4)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .mode (mode),
            .din  (din[8*i +: 8]),
            .ctrl (ctrl[2*i +: 2]),
            .aux  (aux[4*i +: 4]),
            .dout (dout[10*i +: 10]),
            .disp (disp[DISP_W*i +: DISP_W])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
`timescale 1ns/1ps
module tb_tmds_encoder_mc;

    localparam int NCH = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          mode;
    logic [8*NCH-1:0]    din;
    logic [2*NCH-1:0]    ctrl;
    logic [4*NCH-1:0]    aux;
    logic [10*NCH-1:0]   dout;
    logic [5*NCH-1:0]    disp;
    logic [10*NCH-1:0]   dout_nt;
    logic [5*NCH-1:0]    disp_nt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tmds_encoder_mc #(.NCH(NCH), .USE_TERC4(1'b1)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .din(din), .ctrl(ctrl), .aux(aux),
        .dout(dout), .disp(disp)
    );

    tmds_encoder_mc #(.NCH(NCH), .USE_TERC4(1'b0)) u_dut_nt (
        .clk(clk), .rst(rst), .mode(mode), .din(din), .ctrl(ctrl), .aux(aux),
        .dout(dout_nt), .disp(disp_nt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; din = '0; ctrl = '0; aux = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                n_checks++;
                if (dout[10*i +: 10] !== 10'h354) begin
                    n_fail++;
                    $display("FAIL reset_dout lane%0d cyc%0d: got %h want 354", i, c, dout[10*i +: 10]);
                end
                n_checks++;
                if (disp[5*i +: 5] !== 5'd0) begin
                    n_fail++;
                    $display("FAIL reset_disp lane%0d cyc%0d: got %0d want 0", i, c, $signed(disp[5*i +: 5]));
                end
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                n_checks++;
                if (dout[10*i +: 10] !== 10'h354 || disp[5*i +: 5] !== 5'd0) begin
                    n_fail++;
                    $display("FAIL idle lane%0d cyc%0d: got %h/%0d want 354/0", i, c,
                             dout[10*i +: 10], $signed(disp[5*i +: 5]));
                end
            end
        end
    endtask

    task automatic test_video_ff();
        logic [9:0] exp_d [8];
        int         exp_p [8];
        exp_d = '{10'h200, 10'h0FF, 10'h0FF, 10'h200, 10'h0FF, 10'h200, 10'h0FF, 10'h200};
        exp_p = '{-8, -2, 4, -4, 2, -6, 0, -8};
        mode = 2'b01; din = {NCH{8'hFF}};
        tick();
        for (int j = 0; j < 8; j++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                n_checks++;
                if (dout[10*i +: 10] !== exp_d[j] || disp[5*i +: 5] !== 5'(exp_p[j])) begin
                    n_fail++;
                    $display("FAIL video_ff lane%0d sym%0d: got %h/%0d want %h/%0d", i, j,
                             dout[10*i +: 10], $signed(disp[5*i +: 5]), exp_d[j], exp_p[j]);
                end
            end
        end
    endtask

    task automatic test_ctrl();
        logic [9:0] exp1 [3];
        logic [9:0] exp2 [3];
        exp1 = '{10'h0AB, 10'h154, 10'h2AB};
        exp2 = '{10'h154, 10'h2AB, 10'h354};
        mode = 2'b00; ctrl = {2'b11, 2'b10, 2'b01};
        tick(); tick();
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (dout[10*i +: 10] !== exp1[i] || disp[5*i +: 5] !== 5'd0) begin
                n_fail++;
                $display("FAIL ctrl_tok lane%0d: got %h/%0d want %h/0", i,
                         dout[10*i +: 10], $signed(disp[5*i +: 5]), exp1[i]);
            end
        end
        ctrl = {2'b00, 2'b11, 2'b10};
        tick(); tick();
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (dout[10*i +: 10] !== exp2[i]) begin
                n_fail++;
                $display("FAIL ctrl_tok2 lane%0d: got %h want %h", i, dout[10*i +: 10], exp2[i]);
            end
        end
        mode = 2'b01; din = {NCH{8'hFF}};
        tick(); tick();
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (dout[10*i +: 10] !== 10'h200 || disp[5*i +: 5] !== 5'(-8)) begin
                n_fail++;
                $display("FAIL ctrl_restart lane%0d: got %h/%0d want 200/-8", i,
                         dout[10*i +: 10], $signed(disp[5*i +: 5]));
            end
        end
    endtask

    task automatic test_video_00();
        logic [9:0] exp_d [8];
        int         exp_p [8];
        exp_d = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF};
        exp_p = '{-8, 2, -6, 4, -4, 6, -2, 8};
        mode = 2'b00; ctrl = '0;
        tick(); tick();
        mode = 2'b01; din = {NCH{8'h00}};
        tick();
        for (int j = 0; j < 8; j++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                n_checks++;
                if (dout[10*i +: 10] !== exp_d[j] || disp[5*i +: 5] !== 5'(exp_p[j])) begin
                    n_fail++;
                    $display("FAIL video_00 lane%0d sym%0d: got %h/%0d want %h/%0d", i, j,
                             dout[10*i +: 10], $signed(disp[5*i +: 5]), exp_d[j], exp_p[j]);
                end
            end
        end
    endtask

    task automatic test_video_mixed();
        logic [9:0] exp_d [3][3];
        int         exp_p [3][3];
        exp_d = '{'{10'h105, 10'h205, 10'h133},
                  '{10'h3FA, 10'h0FA, 10'h133},
                  '{10'h105, 10'h0FA, 10'h133}};
        exp_p = '{'{-4, -4, 0}, '{2, -2, 0}, '{-2, 0, 0}};
        mode = 2'b00;
        tick(); tick();
        mode = 2'b01; din = {8'h55, 8'hF0, 8'h0F};
        tick();
        for (int j = 0; j < 3; j++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                n_checks++;
                if (dout[10*i +: 10] !== exp_d[j][i] || disp[5*i +: 5] !== 5'(exp_p[j][i])) begin
                    n_fail++;
                    $display("FAIL video_mixed lane%0d sym%0d: got %h/%0d want %h/%0d", i, j,
                             dout[10*i +: 10], $signed(disp[5*i +: 5]), exp_d[j][i], exp_p[j][i]);
                end
            end
        end
    endtask

    task automatic test_terc4_guard();
        logic [9:0] exp1 [3];
        logic [9:0] exp2 [3];
        logic [9:0] exp_nt [3];
        logic [9:0] exp_g;
        exp1   = '{10'h29C, 10'h2C3, 10'h2CC};
        exp2   = '{10'h11E, 10'h28E, 10'h2E2};
        exp_nt = '{10'h0AB, 10'h154, 10'h2AB};
        mode = 2'b10; aux = {4'h8, 4'hF, 4'h0}; ctrl = {2'b11, 2'b10, 2'b01};
        tick(); tick();
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (dout[10*i +: 10] !== exp1[i] || disp[5*i +: 5] !== 5'd0) begin
                n_fail++;
                $display("FAIL terc4_a lane%0d: got %h/%0d want %h/0", i,
                         dout[10*i +: 10], $signed(disp[5*i +: 5]), exp1[i]);
            end
            n_checks++;
            if (dout_nt[10*i +: 10] !== exp_nt[i] || disp_nt[5*i +: 5] !== 5'd0) begin
                n_fail++;
                $display("FAIL no_terc4 lane%0d: got %h/%0d want %h/0", i,
                         dout_nt[10*i +: 10], $signed(disp_nt[5*i +: 5]), exp_nt[i]);
            end
        end
        aux = {4'h3, 4'hC, 4'h5};
        tick(); tick();
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (dout[10*i +: 10] !== exp2[i]) begin
                n_fail++;
                $display("FAIL terc4_b lane%0d: got %h want %h", i, dout[10*i +: 10], exp2[i]);
            end
        end
        mode = 2'b11;
        tick(); tick();
        for (int i = 0; i < NCH; i++) begin
            exp_g = ((i % 2) == 0) ? 10'h2CC : 10'h133;
            n_checks++;
            if (dout[10*i +: 10] !== exp_g || dout_nt[10*i +: 10] !== exp_g) begin
                n_fail++;
                $display("FAIL guard lane%0d: got %h (no-terc4 %h) want %h", i,
                         dout[10*i +: 10], dout_nt[10*i +: 10], exp_g);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_d;
        int         exp_p;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: begin mode = 2'b00; ctrl = {NCH{2'b01}}; end
                1: mode = 2'b11;
                2: begin mode = 2'b10; aux = '0; end
                3: begin mode = 2'b01; din = {NCH{8'hFF}}; end
                default: ;
            endcase
            tick();
            if (s >= 1) begin
                for (int i = 0; i < NCH; i++) begin
                    exp_p = 0;
                    case (s)
                        1: exp_d = 10'h0AB;
                        2: exp_d = ((i % 2) == 0) ? 10'h2CC : 10'h133;
                        3: exp_d = 10'h29C;
                        default: begin exp_d = 10'h200; exp_p = -8; end
                    endcase
                    n_checks++;
                    if (dout[10*i +: 10] !== exp_d || disp[5*i +: 5] !== 5'(exp_p)) begin
                        n_fail++;
                        $display("FAIL b2b lane%0d step%0d: got %h/%0d want %h/%0d", i, s,
                                 dout[10*i +: 10], $signed(disp[5*i +: 5]), exp_d, exp_p);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [9:0] exp_d [4];
        int         exp_p [4];
        exp_d = '{10'h354, 10'h354, 10'h200, 10'h0FF};
        exp_p = '{0, 0, -8, -2};
        tick();
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (dout[10*i +: 10] !== 10'h0FF || disp[5*i +: 5] !== 5'(-2)) begin
                n_fail++;
                $display("FAIL pre_rst lane%0d: got %h/%0d want 0ff/-2", i,
                         dout[10*i +: 10], $signed(disp[5*i +: 5]));
            end
        end
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            rst = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                n_checks++;
                if (dout[10*i +: 10] !== exp_d[j] || disp[5*i +: 5] !== 5'(exp_p[j])) begin
                    n_fail++;
                    $display("FAIL mid_rst lane%0d cyc%0d: got %h/%0d want %h/%0d", i, j,
                             dout[10*i +: 10], $signed(disp[5*i +: 5]), exp_d[j], exp_p[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_video_ff();
        test_ctrl();
        test_video_00();
        test_video_mixed();
        test_terc4_guard();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
